// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer bank: per-channel state encoding
// and the default sizing constants used by timer_bank and timer_channel.
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_NUM_CH        = 4;
   localparam int DEF_WIDTH         = 5;
   localparam int DEF_FLICKER_TICKS = 5;

endpackage

// File: rtl/timer_channel.sv
// One countdown channel: IDLE/RUN/DONE with abort > start > count priority,
// optional auto-reload and a registered end-of-period flicker warning.
module timer_channel
   import timer_pkg::*;
#(
   parameter int WIDTH         = DEF_WIDTH,
   parameter int FLICKER_TICKS = DEF_FLICKER_TICKS
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick,
   input  logic             pause,
   input  logic             start,
   input  logic             abort,
   input  logic             reload,
   input  logic [WIDTH-1:0] length,
   output logic             busy,
   output logic             flicker,
   output logic             done,
   output logic [WIDTH-1:0] remaining
);

   localparam logic [WIDTH-1:0] FLICK_LIM = WIDTH'(FLICKER_TICKS);
   localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

   state_t           state_reg,   state_next;
   logic [WIDTH-1:0] rem_reg,     rem_next;
   logic [WIDTH-1:0] len_reg,     len_next;
   logic             mode_reg,    mode_next;
   logic             done_reg,    done_next;
   logic             flicker_reg, flicker_next;

   function automatic logic in_window(input logic [WIDTH-1:0] v);
      return (v != '0) && (v <= FLICK_LIM);
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg   <= IDLE;
         rem_reg     <= '0;
         len_reg     <= '0;
         mode_reg    <= 1'b0;
         done_reg    <= 1'b0;
         flicker_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         rem_reg     <= rem_next;
         len_reg     <= len_next;
         mode_reg    <= mode_next;
         done_reg    <= done_next;
         flicker_reg <= flicker_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      rem_next     = rem_reg;
      len_next     = len_reg;
      mode_next    = mode_reg;
      done_next    = done_reg;
      flicker_next = flicker_reg;

      if (abort) begin
         state_next   = IDLE;
         rem_next     = '0;
         done_next    = 1'b0;
         flicker_next = 1'b0;
      end else if (start) begin
         // a tick in the start cycle is deliberately dropped
         len_next  = length;
         mode_next = reload;
         if (length != '0) begin
            state_next   = RUN;
            rem_next     = length;
            done_next    = 1'b0;
            flicker_next = in_window(length);
         end else begin
            state_next   = DONE;
            rem_next     = '0;
            done_next    = 1'b1;
            flicker_next = 1'b0;
         end
      end else begin
         case (state_reg)
            RUN: begin
               // reload expiry gives a single-cycle done pulse
               done_next = 1'b0;
               if (tick && !pause) begin
                  if (rem_reg == ONE) begin
                     done_next = 1'b1;
                     if (mode_reg) begin
                        rem_next     = len_reg;
                        flicker_next = in_window(len_reg);
                     end else begin
                        state_next   = DONE;
                        rem_next     = '0;
                        flicker_next = 1'b0;
                     end
                  end else begin
                     rem_next     = rem_reg - ONE;
                     flicker_next = in_window(rem_reg - ONE);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign busy      = (state_reg == RUN);
   assign flicker   = flicker_reg;
   assign done      = done_reg;
   assign remaining = rem_reg;

endmodule

// File: rtl/timer_bank.sv
// Bank of NUM_CH independent countdown timers sharing tick and pause;
// only packs and unpacks the per-channel vector ports.
module timer_bank
   import timer_pkg::*;
#(
   parameter int NUM_CH        = DEF_NUM_CH,
   parameter int WIDTH         = DEF_WIDTH,
   parameter int FLICKER_TICKS = DEF_FLICKER_TICKS
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    tick,
   input  logic                    pause,
   input  logic [NUM_CH-1:0]       t_start,
   input  logic [NUM_CH-1:0]       t_abort,
   input  logic [NUM_CH-1:0]       t_reload,
   input  logic [NUM_CH*WIDTH-1:0] t_length,
   output logic [NUM_CH-1:0]       t_busy,
   output logic [NUM_CH-1:0]       t_flicker,
   output logic [NUM_CH-1:0]       t_done,
   output logic [NUM_CH*WIDTH-1:0] t_remaining
);

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         timer_channel #(
            .WIDTH         (WIDTH),
            .FLICKER_TICKS (FLICKER_TICKS)
         ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .tick      (tick),
            .pause     (pause),
            .start     (t_start[gi]),
            .abort     (t_abort[gi]),
            .reload    (t_reload[gi]),
            .length    (t_length[gi*WIDTH +: WIDTH]),
            .busy      (t_busy[gi]),
            .flicker   (t_flicker[gi]),
            .done      (t_done[gi]),
            .remaining (t_remaining[gi*WIDTH +: WIDTH])
         );
      end
   endgenerate

endmodule

// File: tb/tb_timer_bank.sv
// Self-checking bench for timer_bank: a constant vector table on channel 0,
// hand-written multi-cycle sequences, and random traffic against a model.
module tb_timer_bank;

   localparam int NUM_CH = 4;
   localparam int WIDTH  = 5;
   localparam int FT     = 5;

   logic                    clk = 1'b0;
   logic                    reset = 1'b0;
   logic                    tick = 1'b0;
   logic                    pause = 1'b0;
   logic [NUM_CH-1:0]       t_start = '0;
   logic [NUM_CH-1:0]       t_abort = '0;
   logic [NUM_CH-1:0]       t_reload = '0;
   logic [NUM_CH*WIDTH-1:0] t_length = '0;
   logic [NUM_CH-1:0]       t_busy;
   logic [NUM_CH-1:0]       t_flicker;
   logic [NUM_CH-1:0]       t_done;
   logic [NUM_CH*WIDTH-1:0] t_remaining;

   int tests = 0;
   int fails = 0;

   timer_bank #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .FLICKER_TICKS(FT)) dut (
      .clk         (clk),
      .reset       (reset),
      .tick        (tick),
      .pause       (pause),
      .t_start     (t_start),
      .t_abort     (t_abort),
      .t_reload    (t_reload),
      .t_length    (t_length),
      .t_busy      (t_busy),
      .t_flicker   (t_flicker),
      .t_done      (t_done),
      .t_remaining (t_remaining)
   );

   always #5 clk = ~clk;

   // Reference model: phase 0=idle, 1=counting, 2=expired
   int m_ph [NUM_CH];
   int m_rem[NUM_CH];
   int m_len[NUM_CH];
   bit m_rl [NUM_CH];
   bit m_dn [NUM_CH];

   task automatic model_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         m_ph[c] = 0; m_rem[c] = 0; m_len[c] = 0; m_rl[c] = 0; m_dn[c] = 0;
      end
   endtask

   function automatic int get_rem(int c);
      return int'(t_remaining[c*WIDTH +: WIDTH]);
   endfunction

   task automatic set_len(int c, int l);
      t_length[c*WIDTH +: WIDTH] = WIDTH'(l);
   endtask

   // Advance one clock: model consumes the inputs present before the edge.
   task automatic step();
      int n_ph[NUM_CH], n_rem[NUM_CH], n_len[NUM_CH];
      bit n_rl[NUM_CH], n_dn[NUM_CH];
      for (int c = 0; c < NUM_CH; c++) begin
         int l;
         l = int'(t_length[c*WIDTH +: WIDTH]);
         n_ph[c] = m_ph[c]; n_rem[c] = m_rem[c]; n_len[c] = m_len[c];
         n_rl[c] = m_rl[c]; n_dn[c] = m_dn[c];
         if (t_abort[c]) begin
            n_ph[c] = 0; n_rem[c] = 0; n_dn[c] = 0;
         end else if (t_start[c]) begin
            n_len[c] = l; n_rl[c] = t_reload[c];
            if (l > 0) begin n_ph[c] = 1; n_rem[c] = l; n_dn[c] = 0; end
            else       begin n_ph[c] = 2; n_rem[c] = 0; n_dn[c] = 1; end
         end else if (m_ph[c] == 1) begin
            n_dn[c] = 0;
            if (tick && !pause) begin
               if (m_rem[c] == 1) begin
                  n_dn[c] = 1;
                  if (m_rl[c]) n_rem[c] = m_len[c];
                  else begin n_ph[c] = 2; n_rem[c] = 0; end
               end else begin
                  n_rem[c] = m_rem[c] - 1;
               end
            end
         end
      end
      @(posedge clk);
      #1;
      for (int c = 0; c < NUM_CH; c++) begin
         m_ph[c] = n_ph[c]; m_rem[c] = n_rem[c]; m_len[c] = n_len[c];
         m_rl[c] = n_rl[c]; m_dn[c] = n_dn[c];
      end
   endtask

   task automatic check_all(string tag);
      for (int c = 0; c < NUM_CH; c++) begin
         bit eb, ef;
         eb = (m_ph[c] == 1);
         ef = (m_ph[c] == 1) && (m_rem[c] > 0) && (m_rem[c] <= FT);
         tests++;
         if (t_busy[c] !== eb || t_flicker[c] !== ef || t_done[c] !== m_dn[c] ||
             get_rem(c) != m_rem[c]) begin
            fails++;
            $display("FAIL %s ch%0d: got busy=%b flick=%b done=%b rem=%0d, want busy=%b flick=%b done=%b rem=%0d",
                     tag, c, t_busy[c], t_flicker[c], t_done[c], get_rem(c),
                     eb, ef, m_dn[c], m_rem[c]);
         end
      end
   endtask

   typedef struct {
      bit st, ab, rl;
      int len;
      bit tk, ps;
      bit eb, ef, ed;
      int er;
   } vec_t;

   function automatic vec_t mkv(bit st, bit ab, bit rl, int len, bit tk, bit ps,
                                bit eb, bit ef, bit ed, int er);
      vec_t v;
      v.st = st; v.ab = ab; v.rl = rl; v.len = len; v.tk = tk; v.ps = ps;
      v.eb = eb; v.ef = ef; v.ed = ed; v.er = er;
      return v;
   endfunction

   vec_t tbl[26];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1, "timeout");
   end

   initial begin
      int cnt, qual, l;

      // Channel-0 vectors: {start, abort, reload, len, tick, pause} -> {busy, flick, done, rem}
      tbl[0]  = mkv(1,0,0,8,1,0, 1,0,0,8);
      tbl[1]  = mkv(0,0,0,0,1,0, 1,0,0,7);
      tbl[2]  = mkv(0,0,0,0,1,0, 1,0,0,6);
      tbl[3]  = mkv(0,0,0,0,1,0, 1,1,0,5);
      tbl[4]  = mkv(0,0,0,0,1,0, 1,1,0,4);
      tbl[5]  = mkv(0,0,0,0,1,0, 1,1,0,3);
      tbl[6]  = mkv(0,0,0,0,1,0, 1,1,0,2);
      tbl[7]  = mkv(0,0,0,0,1,0, 1,1,0,1);
      tbl[8]  = mkv(0,0,0,0,1,0, 0,0,1,0);
      tbl[9]  = mkv(0,0,0,0,1,0, 0,0,1,0);
      tbl[10] = mkv(1,1,0,3,1,0, 0,0,0,0);
      tbl[11] = mkv(1,0,0,0,1,0, 0,0,1,0);
      tbl[12] = mkv(1,0,0,3,1,0, 1,1,0,3);
      tbl[13] = mkv(0,0,0,0,0,0, 1,1,0,3);
      tbl[14] = mkv(0,0,0,0,1,1, 1,1,0,3);
      tbl[15] = mkv(0,0,0,0,1,0, 1,1,0,2);
      tbl[16] = mkv(1,0,0,7,1,0, 1,0,0,7);
      tbl[17] = mkv(0,0,0,0,1,0, 1,0,0,6);
      tbl[18] = mkv(0,1,0,0,1,0, 0,0,0,0);
      tbl[19] = mkv(0,0,0,0,1,0, 0,0,0,0);
      tbl[20] = mkv(1,0,1,3,1,0, 1,1,0,3);
      tbl[21] = mkv(0,0,0,0,1,0, 1,1,0,2);
      tbl[22] = mkv(0,0,0,0,1,0, 1,1,0,1);
      tbl[23] = mkv(0,0,0,0,1,0, 1,1,1,3);
      tbl[24] = mkv(0,0,0,0,1,0, 1,1,0,2);
      tbl[25] = mkv(0,1,0,0,1,0, 0,0,0,0);

      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      reset = 1'b1;

      for (int i = 0; i < 26; i++) begin
         t_start[0] = tbl[i].st; t_abort[0] = tbl[i].ab; t_reload[0] = tbl[i].rl;
         set_len(0, tbl[i].len); tick = tbl[i].tk; pause = tbl[i].ps;
         step();
         tests++;
         if (t_busy[0] !== tbl[i].eb || t_flicker[0] !== tbl[i].ef ||
             t_done[0] !== tbl[i].ed || get_rem(0) != tbl[i].er) begin
            fails++;
            $display("FAIL vec%0d: got busy=%b flick=%b done=%b rem=%0d, want busy=%b flick=%b done=%b rem=%0d",
                     i, t_busy[0], t_flicker[0], t_done[0], get_rem(0),
                     tbl[i].eb, tbl[i].ef, tbl[i].ed, tbl[i].er);
         end
      end
      t_start = '0; t_abort = '0; t_reload = '0; pause = 1'b0;

      // Reload on ch2, L=4: done pulses at cycles 5, 9, 13
      tick = 1'b1; set_len(2, 4); t_reload[2] = 1'b1; t_start[2] = 1'b1;
      for (int k = 1; k <= 13; k++) begin
         bit ed;
         int er;
         step();
         t_start[2] = 1'b0; t_reload[2] = 1'b0;
         ed = (k > 1) && ((k - 1) % 4 == 0);
         er = 4 - ((k - 1) % 4);
         tests++;
         if (t_done[2] !== ed || get_rem(2) != er || t_busy[2] !== 1'b1) begin
            fails++;
            $display("FAIL reload_k%0d: got done=%b rem=%0d busy=%b, want done=%b rem=%0d busy=1",
                     k, t_done[2], get_rem(2), t_busy[2], ed, er);
         end
      end
      t_abort[2] = 1'b1;
      step();
      t_abort[2] = 1'b0;
      check_all("reload_abort");

      // Latency with tick held high: done exactly L+1 cycles after start
      for (int r = 0; r < 3; r++) begin
         l = $urandom_range(1, 20);
         set_len(3, l); t_start[3] = 1'b1; tick = 1'b1;
         step();
         t_start[3] = 1'b0;
         cnt = 1;
         while (!t_done[3] && cnt < 40) begin
            step();
            cnt++;
         end
         tests++;
         if (cnt != l + 1) begin
            fails++;
            $display("FAIL latency L=%0d: got %0d cycles, want %0d", l, cnt, l + 1);
         end
      end

      // Tick every 2nd cycle with a 3-cycle pause: expiry after 6 qualifying ticks
      set_len(1, 6); t_start[1] = 1'b1; tick = 1'b0;
      step();
      t_start[1] = 1'b0;
      qual = 0; cnt = 0;
      while (!t_done[1] && cnt < 60) begin
         tick  = (cnt % 2 == 0);
         pause = (cnt >= 4 && cnt < 7);
         if (tick && !pause) qual++;
         step();
         check_all("gating");
         cnt++;
      end
      tick = 1'b0; pause = 1'b0;
      tests++;
      if (qual != 6 || !t_done[1]) begin
         fails++;
         $display("FAIL gating: got %0d qualifying ticks done=%b, want 6 done=1", qual, t_done[1]);
      end

      // Reset asserted between edges clears outputs immediately
      for (int c = 0; c < NUM_CH; c++) set_len(c, 3 + 2 * c);
      t_start = '1; tick = 1'b1;
      step();
      t_start = '0;
      step();
      #2;
      reset = 1'b0;
      #1;
      tests++;
      if (t_busy !== '0 || t_flicker !== '0 || t_done !== '0 || t_remaining !== '0) begin
         fails++;
         $display("FAIL async_reset: got busy=%b flick=%b done=%b rem=%h, want all 0",
                  t_busy, t_flicker, t_done, t_remaining);
      end
      model_reset();
      #2;
      reset = 1'b1;
      for (int c = 0; c < NUM_CH; c++) set_len(c, 2 + 3 * c);
      t_start = 4'b0101;
      step();
      t_start = 4'b1010;
      check_all("indep");
      step();
      t_start = '0;
      for (int k = 0; k < 12; k++) begin
         step();
         check_all("indep");
      end

      // Random traffic against the model
      for (int k = 0; k < 1500; k++) begin
         for (int c = 0; c < NUM_CH; c++) begin
            t_start[c]  = ($urandom_range(0, 7) == 0);
            t_abort[c]  = ($urandom_range(0, 15) == 0);
            t_reload[c] = $urandom_range(0, 1);
            set_len(c, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 9));
         end
         tick  = ($urandom_range(0, 3) != 0);
         pause = ($urandom_range(0, 7) == 0);
         step();
         check_all("rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
